// File: rtl/accumulator_bank.sv
// Column accumulator bank for the systolic array's vertical outputs.
// Sums ARR_SIZE signed column partial-sums across beats. On request it writes either
// the per-column results or a single cross-column sum to the output buffer through a
// valid/ready handshake.
// Build option: define ACC_SATURATE_EN to clamp accumulator adds and output narrowing
// (any clamp raises the sticky overflow flag); undefined builds wrap and truncate.
module accumulator_bank #(
    parameter int unsigned ARR_SIZE    = 4,
    parameter int unsigned VERTICAL_BW = 32,
    parameter int unsigned ACC_W       = 40,
    parameter int unsigned OUT_W       = 32,
    parameter int unsigned ADDR_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] accumulated_val,
    input  logic                         acc_reset,
    input  logic                         mode,
    input  logic                         store_output,
    input  logic [ADDR_W-1:0]            op_buffer_address,
    output logic [ARR_SIZE*OUT_W-1:0]    output_data,
    output logic [ADDR_W-1:0]            output_buffer_addr,
    output logic                         output_buffer_enable,
    input  logic                         output_ready,
    output logic                         busy,
    output logic                         overflow
);

    localparam int unsigned RED_W = ACC_W + $clog2(ARR_SIZE);
    localparam int unsigned IDX_W = $clog2(ARR_SIZE);

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_REDUCE = 2'd1,
        ST_STORE  = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic signed [ACC_W-1:0]    acc      [ARR_SIZE];
    logic signed [ACC_W-1:0]    acc_nxt  [ARR_SIZE];
    logic signed [RED_W-1:0]    red_sum, red_sum_nxt, sum_add;
    logic signed [ACC_W-1:0]    sel_acc;
    logic [IDX_W-1:0]           red_idx, red_idx_nxt;
    logic [ARR_SIZE*OUT_W-1:0]  data_nxt;
    logic [ADDR_W-1:0]          addr_nxt;
    logic                       en_nxt;
    logic                       busy_nxt;
    logic                       ovf_nxt;

`ifdef ACC_SATURATE_EN
    localparam logic signed [RED_W-1:0] OUT_MAX = RED_W'({1'b0, {(OUT_W-1){1'b1}}});
    localparam logic signed [RED_W-1:0] OUT_MIN = RED_W'($signed({1'b1, {(OUT_W-1){1'b0}}}));

    // One extra bit of headroom so the true sum is visible before clamping.
    function automatic logic signed [ACC_W:0] acc_wide(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [VERTICAL_BW-1:0] b);
        return (ACC_W+1)'(a) + (ACC_W+1)'(b);
    endfunction

    function automatic logic acc_ovf(input logic signed [ACC_W:0] w);
        return w[ACC_W] != w[ACC_W-1];
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [VERTICAL_BW-1:0] b);
        logic signed [ACC_W:0] w;
        w = acc_wide(a, b);
        if (acc_ovf(w)) begin
            return w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return w[ACC_W-1:0];
    endfunction

    function automatic logic narrow_ovf(input logic signed [RED_W-1:0] x);
        return (x > OUT_MAX) || (x < OUT_MIN);
    endfunction

    function automatic logic [OUT_W-1:0] narrow(input logic signed [RED_W-1:0] x);
        if (x > OUT_MAX) return OUT_W'(OUT_MAX);
        if (x < OUT_MIN) return OUT_W'(OUT_MIN);
        return OUT_W'(x);
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [VERTICAL_BW-1:0] b);
        return a + ACC_W'(b);
    endfunction

    function automatic logic [OUT_W-1:0] narrow(input logic signed [RED_W-1:0] x);
        return OUT_W'(x);
    endfunction
`endif

    // Lane currently being folded into the reduce sum.
    always_comb begin
        sel_acc = '0;
        for (int k = 0; k < int'(ARR_SIZE); k++) begin
            if (IDX_W'(k) == red_idx) sel_acc = acc[k];
        end
        sum_add = red_sum + RED_W'(sel_acc);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        acc_nxt     = acc;
        red_sum_nxt = red_sum;
        red_idx_nxt = red_idx;
        data_nxt    = output_data;
        addr_nxt    = output_buffer_addr;
        en_nxt      = output_buffer_enable;
        ovf_nxt     = overflow;

        case (state)
            ST_ACC: begin
                if (acc_reset) begin
                    acc_nxt = '{default: '0};
                    ovf_nxt = 1'b0;
                end else if (in_valid) begin
                    for (int k = 0; k < int'(ARR_SIZE); k++) begin
                        acc_nxt[k] = acc_add(acc[k],
                            $signed(accumulated_val[k*VERTICAL_BW +: VERTICAL_BW]));
`ifdef ACC_SATURATE_EN
                        if (acc_ovf(acc_wide(acc[k],
                                $signed(accumulated_val[k*VERTICAL_BW +: VERTICAL_BW]))))
                            ovf_nxt = 1'b1;
`endif
                    end
                end
                if (store_output) begin
                    addr_nxt    = op_buffer_address;
                    red_idx_nxt = '0;
                    red_sum_nxt = '0;
                    if (mode) begin
                        state_nxt = ST_REDUCE;
                    end else begin
                        state_nxt = ST_STORE;
                        en_nxt    = 1'b1;
                        for (int k = 0; k < int'(ARR_SIZE); k++) begin
                            data_nxt[k*OUT_W +: OUT_W] = narrow(RED_W'(acc_nxt[k]));
`ifdef ACC_SATURATE_EN
                            if (narrow_ovf(RED_W'(acc_nxt[k]))) ovf_nxt = 1'b1;
`endif
                        end
                    end
                end
            end
            ST_REDUCE: begin
                if (acc_reset) begin
                    acc_nxt   = '{default: '0};
                    ovf_nxt   = 1'b0;
                    en_nxt    = 1'b0;
                    state_nxt = ST_ACC;
                end else begin
                    red_sum_nxt = sum_add;
                    if (red_idx == IDX_W'(ARR_SIZE-1)) begin
                        state_nxt             = ST_STORE;
                        en_nxt                = 1'b1;
                        data_nxt              = '0;
                        data_nxt[OUT_W-1:0]   = narrow(sum_add);
`ifdef ACC_SATURATE_EN
                        if (narrow_ovf(sum_add)) ovf_nxt = 1'b1;
`endif
                    end else begin
                        red_idx_nxt = red_idx + IDX_W'(1);
                    end
                end
            end
            ST_STORE: begin
                if (acc_reset) begin
                    acc_nxt   = '{default: '0};
                    ovf_nxt   = 1'b0;
                    en_nxt    = 1'b0;
                    state_nxt = ST_ACC;
                end else if (output_ready) begin
                    acc_nxt   = '{default: '0};
                    en_nxt    = 1'b0;
                    state_nxt = ST_ACC;
                end
            end
            default: begin
                state_nxt = ST_ACC;
                en_nxt    = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != ST_ACC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                <= ST_ACC;
            acc                  <= '{default: '0};
            red_sum              <= '0;
            red_idx              <= '0;
            output_data          <= '0;
            output_buffer_addr   <= '0;
            output_buffer_enable <= 1'b0;
            busy                 <= 1'b0;
            overflow             <= 1'b0;
        end else begin
            state                <= state_nxt;
            acc                  <= acc_nxt;
            red_sum              <= red_sum_nxt;
            red_idx              <= red_idx_nxt;
            output_data          <= data_nxt;
            output_buffer_addr   <= addr_nxt;
            output_buffer_enable <= en_nxt;
            busy                 <= busy_nxt;
            overflow             <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_accumulator_bank.sv
// Self-checking bench for accumulator_bank: directed scenarios plus randomized
// store transactions checked against an arithmetic reference model.
module tb_accumulator_bank;

    localparam int N   = 4;
    localparam int VBW = 32;
    localparam int AW  = 40;
    localparam int OW  = 32;
    localparam int ADW = 4;

    localparam longint ACC_MAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (AW-1));
    localparam longint OUT_MAX = (longint'(1) <<< (OW-1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) <<< (OW-1));

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [N*VBW-1:0]   accumulated_val;
    logic               acc_reset;
    logic               mode;
    logic               store_output;
    logic [ADW-1:0]     op_buffer_address;
    logic [N*OW-1:0]    output_data;
    logic [ADW-1:0]     output_buffer_addr;
    logic               output_buffer_enable;
    logic               output_ready;
    logic               busy;
    logic               overflow;

    accumulator_bank #(
        .ARR_SIZE(N), .VERTICAL_BW(VBW), .ACC_W(AW), .OUT_W(OW), .ADDR_W(ADW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .accumulated_val(accumulated_val),
        .acc_reset(acc_reset), .mode(mode), .store_output(store_output),
        .op_buffer_address(op_buffer_address), .output_data(output_data),
        .output_buffer_addr(output_buffer_addr), .output_buffer_enable(output_buffer_enable),
        .output_ready(output_ready), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint acc_m [N];
    bit     ovf_m;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic longint m_wrap(input longint x, input int w);
        longint m, r;
        m = longint'(1) <<< w;
        r = x & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < N; k++) acc_m[k] = 0;
    endtask

    task automatic m_beat(input logic [127:0] v);
        logic [31:0] w;
        longint s;
        for (int k = 0; k < N; k++) begin
            w = v[k*32 +: 32];
            s = acc_m[k] + longint'($signed(w));
`ifdef ACC_SATURATE_EN
            if (s > ACC_MAX) begin s = ACC_MAX; ovf_m = 1'b1; end
            if (s < ACC_MIN) begin s = ACC_MIN; ovf_m = 1'b1; end
`else
            s = m_wrap(s, AW);
`endif
            acc_m[k] = s;
        end
    endtask

    task automatic m_narrow(input longint x, output logic [31:0] r);
`ifdef ACC_SATURATE_EN
        if (x > OUT_MAX) begin x = OUT_MAX; ovf_m = 1'b1; end
        if (x < OUT_MIN) begin x = OUT_MIN; ovf_m = 1'b1; end
        r = 32'(x);
`else
        r = 32'(m_wrap(x, OW));
`endif
    endtask

    task automatic m_expect(input bit md, output logic [127:0] e);
        logic [31:0] r;
        longint sum;
        e = '0;
        if (md) begin
            sum = 0;
            for (int k = 0; k < N; k++) sum += acc_m[k];
            m_narrow(sum, r);
            e[31:0] = r;
        end else begin
            for (int k = 0; k < N; k++) begin
                m_narrow(acc_m[k], r);
                e[k*32 +: 32] = r;
            end
        end
    endtask

    task automatic beat(input logic [127:0] v);
        in_valid        = 1'b1;
        accumulated_val = v;
        m_beat(v);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic do_acc_reset();
        acc_reset = 1'b1;
        cycle();
        acc_reset = 1'b0;
        m_clear();
        ovf_m = 1'b0;
    endtask

    function automatic logic [127:0] rand_beat();
        logic [127:0] v;
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
                0:       v[k*32 +: 32] = 32'h7FFF_FFFF;
                1:       v[k*32 +: 32] = 32'h8000_0000;
                2:       v[k*32 +: 32] = 32'($urandom_range(0, 200)) - 32'd100;
                default: v[k*32 +: 32] = 32'($urandom);
            endcase
        end
        return v;
    endfunction

    // Full store transaction: request, latency, hold while not ready, handshake.
    task automatic do_store(input bit md, input logic [3:0] ad, input int ready_delay,
                            input bit with_beat, input logic [127:0] bv);
        logic [127:0] e;
        int lat;
        store_output      = 1'b1;
        mode              = md;
        op_buffer_address = ad;
        in_valid          = with_beat;
        accumulated_val   = bv;
        output_ready      = (ready_delay == 0);
        if (with_beat) m_beat(bv);
        m_expect(md, e);
        cycle();
        store_output = 1'b0;
        in_valid     = 1'b0;
        lat = 1;
        while (!output_buffer_enable && lat < 20) begin
            cycle();
            lat++;
        end
        chk("latency", 128'(lat), md ? 128'(N + 1) : 128'd1);
        chk("data", output_data, e);
        chk("addr", 128'(output_buffer_addr), 128'(ad));
        chk("busy_store", 128'(busy), 128'd1);
        chk("ovf_store", 128'(overflow), 128'(ovf_m));
        for (int i = 0; i < ready_delay; i++) begin
            in_valid        = 1'b1;
            accumulated_val = rand_beat();
            store_output    = 1'b1;
            op_buffer_address = ~ad;
            cycle();
            chk("hold_en", 128'(output_buffer_enable), 128'd1);
            chk("hold_data", output_data, e);
            chk("hold_addr", 128'(output_buffer_addr), 128'(ad));
            chk("hold_busy", 128'(busy), 128'd1);
        end
        in_valid     = 1'b0;
        store_output = 1'b0;
        output_ready = 1'b1;
        cycle();
        chk("en_drop", 128'(output_buffer_enable), 128'd0);
        chk("busy_drop", 128'(busy), 128'd0);
        chk("data_keep", output_data, e);
        chk("addr_keep", 128'(output_buffer_addr), 128'(ad));
        output_ready = 1'b0;
        m_clear();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, output_data, 128'd0);
        chk({tag, "_addr"}, 128'(output_buffer_addr), 128'd0);
        chk({tag, "_en"}, 128'(output_buffer_enable), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_ovf"}, 128'(overflow), 128'd0);
    endtask

    // Assert rst between clock edges and confirm the outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        m_clear();
        ovf_m = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; accumulated_val = '0; acc_reset = 1'b0;
        mode = 1'b0; store_output = 1'b0; op_buffer_address = '0; output_ready = 1'b0;
        m_clear();
        ovf_m = 1'b0;
        cycle();
        cycle();
        chk_reset_outputs("reset");
        rst = 1'b0;
        cycle();

        // Per-column result of three beats.
        for (int i = 0; i < 3; i++) beat(pack4(1, 2, 3, 4));
        do_store(1'b0, 4'd5, 0, 1'b0, '0);
        chk("t1_lanes", output_data, pack4(3, 6, 9, 12));

        // Reduced sum of the same beats.
        for (int i = 0; i < 3; i++) beat(pack4(1, 2, 3, 4));
        do_store(1'b1, 4'd9, 0, 1'b0, '0);
        chk("t2_lanes", output_data, pack4(30, 0, 0, 0));

        // Back-pressure: beats during STORE are dropped, then accumulators auto-clear.
        for (int i = 0; i < 3; i++) beat(pack4(1, 2, 3, 4));
        do_store(1'b0, 4'd3, 3, 1'b0, '0);
        do_store(1'b0, 4'd7, 0, 1'b0, '0);
        chk("t3_cleared", output_data, 128'd0);

        // Beat in the store cycle is part of the result.
        beat(pack4(10, 20, 30, 40));
        do_store(1'b0, 4'd2, 1, 1'b1, pack4(1, 1, 1, 1));
        chk("same_cycle_beat", output_data, pack4(11, 21, 31, 41));

        // Output narrowing at the positive boundary.
        do_acc_reset();
        beat(pack4(32'h7FFF_FFFF, 0, 0, 0));
        beat(pack4(1, 0, 0, 0));
        do_store(1'b0, 4'd4, 0, 1'b0, '0);
`ifdef ACC_SATURATE_EN
        chk("t4_lane0", 128'(output_data[31:0]), 128'h7FFF_FFFF);
        chk("t4_ovf", 128'(overflow), 128'd1);
`else
        chk("t4_lane0", 128'(output_data[31:0]), 128'h8000_0000);
        chk("t4_ovf", 128'(overflow), 128'd0);
`endif
        do_acc_reset();
        chk("ovf_cleared", 128'(overflow), 128'd0);

        // Abort from STORE with acc_reset.
        beat(pack4(5, 6, 7, 8));
        store_output = 1'b1; mode = 1'b0; op_buffer_address = 4'd11; output_ready = 1'b0;
        cycle();
        store_output = 1'b0;
        cycle();
        chk("t5_en_pre", 128'(output_buffer_enable), 128'd1);
        do_acc_reset();
        chk("t5_en_abort", 128'(output_buffer_enable), 128'd0);
        chk("t5_busy_abort", 128'(busy), 128'd0);
        do_store(1'b0, 4'd1, 0, 1'b0, '0);
        chk("t5_zero", output_data, 128'd0);

        // Abort from REDUCE with acc_reset.
        beat(pack4(5, 6, 7, 8));
        store_output = 1'b1; mode = 1'b1; op_buffer_address = 4'd12;
        cycle();
        store_output = 1'b0;
        cycle();
        do_acc_reset();
        chk("reduce_abort_busy", 128'(busy), 128'd0);
        cycle();
        chk("reduce_abort_en", 128'(output_buffer_enable), 128'd0);
        do_store(1'b1, 4'd13, 0, 1'b0, '0);
        chk("reduce_abort_zero", output_data, 128'd0);

        // Asynchronous reset mid-ACC.
        beat(pack4(9, 9, 9, 9));
        async_reset("rst_acc");
        do_store(1'b0, 4'd6, 0, 1'b0, '0);
        chk("rst_acc_zero", output_data, 128'd0);

        // Asynchronous reset mid-REDUCE.
        beat(pack4(3, 3, 3, 3));
        do_store(1'b0, 4'd8, 0, 1'b0, '0);
        beat(pack4(3, 3, 3, 3));
        store_output = 1'b1; mode = 1'b1; op_buffer_address = 4'd14;
        cycle();
        store_output = 1'b0;
        cycle();
        chk("mid_reduce_busy", 128'(busy), 128'd1);
        async_reset("rst_reduce");
        do_store(1'b0, 4'd10, 0, 1'b0, '0);
        chk("rst_reduce_zero", output_data, 128'd0);

        // Asynchronous reset with a write pending.
        beat(pack4(2, 2, 2, 2));
        store_output = 1'b1; mode = 1'b0; op_buffer_address = 4'd15; output_ready = 1'b0;
        cycle();
        store_output = 1'b0;
        chk("pending_en", 128'(output_buffer_enable), 128'd1);
        async_reset("rst_store");

        // Randomized transactions.
        for (int it = 0; it < 30; it++) begin
            int nb;
            if ($urandom_range(0, 5) == 0) do_acc_reset();
            nb = $urandom_range(0, 5);
            for (int b = 0; b < nb; b++) beat(rand_beat());
            do_store(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)), rand_beat());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
